// File: rtl/traceback_walker.sv
// Traceback walker: follows the captured direction matrix back from the max-score
// cell and streams one alignment operation per cycle over a valid/ready interface.
module traceback_walker #(
    parameter int N  = 16,
    parameter int AW = 4,
    parameter int LW = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2*N*N-1:0]  tb_matrix,
    input  logic [2*N-1:0]    seq_a,
    input  logic [2*N-1:0]    seq_b,
    input  logic [AW-1:0]     start_row,
    input  logic [AW-1:0]     start_col,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [1:0]        op_code,
    output logic [AW-1:0]     op_row,
    output logic [AW-1:0]     op_col,
    output logic              op_last,
    output logic              busy,
    output logic              done,
    output logic [LW-1:0]     path_len
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_DIAG = 2'b01;
    localparam logic [1:0] DIR_UP   = 2'b10;
    localparam logic [1:0] DIR_LEFT = 2'b11;

    state_t state, state_next;

    logic [2*N*N-1:0] mat_q;
    logic [2*N-1:0]   sa_q;
    logic [2*N-1:0]   sb_q;
    logic [AW-1:0]    row_q;
    logic [AW-1:0]    col_q;

    logic [1:0]       cur_dir;
    logic [1:0]       pred_dir;
    logic [AW-1:0]    pred_row;
    logic [AW-1:0]    pred_col;
    logic             edge_hit;
    logic             last_op;
    logic             xfer;

    // N is a power of two, so {row,col} is the flat cell index directly
    always_comb begin
        cur_dir  = mat_q[{row_q, col_q, 1'b0} +: 2];
        pred_row = row_q;
        pred_col = col_q;
        edge_hit = 1'b0;
        case (cur_dir)
            DIR_DIAG: begin
                pred_row = row_q - AW'(1);
                pred_col = col_q - AW'(1);
                edge_hit = (row_q == '0) || (col_q == '0);
            end
            DIR_UP: begin
                pred_row = row_q - AW'(1);
                edge_hit = (row_q == '0);
            end
            DIR_LEFT: begin
                pred_col = col_q - AW'(1);
                edge_hit = (col_q == '0);
            end
            default: ;
        endcase
        // Predecessor lookup may wrap when edge_hit is set; edge_hit already forces last
        pred_dir = mat_q[{pred_row, pred_col, 1'b0} +: 2];
        last_op  = edge_hit || (pred_dir == DIR_STOP) || (path_len == LW'(2*N-2));
    end

    always_comb begin
        state_next = state;
        op_valid   = 1'b0;
        op_code    = 2'b00;
        op_row     = '0;
        op_col     = '0;
        op_last    = 1'b0;
        busy       = (state == WALK);
        done       = (state == FIN);
        xfer       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = WALK;
            end
            WALK: begin
                if (cur_dir == DIR_STOP) begin
                    state_next = FIN;
                end else begin
                    op_valid = 1'b1;
                    op_row   = row_q;
                    op_col   = col_q;
                    op_last  = last_op;
                    if (cur_dir == DIR_DIAG)
                        op_code = (sa_q[{row_q, 1'b0} +: 2] == sb_q[{col_q, 1'b0} +: 2]) ? 2'b00 : 2'b01;
                    else
                        op_code = cur_dir;
                    xfer = op_ready;
                    if (op_ready && last_op) state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Walk position advances only on a transfer, which keeps op_* stable while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mat_q    <= '0;
            sa_q     <= '0;
            sb_q     <= '0;
            row_q    <= '0;
            col_q    <= '0;
            path_len <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                mat_q    <= tb_matrix;
                sa_q     <= seq_a;
                sb_q     <= seq_b;
                row_q    <= start_row;
                col_q    <= start_col;
                path_len <= '0;
            end else if (xfer) begin
                path_len <= path_len + LW'(1);
                if (!last_op) begin
                    row_q <= pred_row;
                    col_q <= pred_col;
                end
            end
        end
    end

endmodule

// File: tb/tb_traceback_walker.sv
// Self-checking bench for traceback_walker: directed scenarios plus random matrices,
// checked against a coordinate-walking reference model.
module tb_traceback_walker;

    localparam int N  = 16;
    localparam int AW = 4;
    localparam int LW = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [2*N*N-1:0]  tb_matrix;
    logic [2*N-1:0]    seq_a;
    logic [2*N-1:0]    seq_b;
    logic [AW-1:0]     start_row;
    logic [AW-1:0]     start_col;
    logic              op_valid;
    logic              op_ready;
    logic [1:0]        op_code;
    logic [AW-1:0]     op_row;
    logic [AW-1:0]     op_col;
    logic              op_last;
    logic              busy;
    logic              done;
    logic [LW-1:0]     path_len;

    always #5 clk = ~clk;

    traceback_walker #(.N(N), .AW(AW), .LW(LW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .tb_matrix(tb_matrix),
        .seq_a(seq_a),
        .seq_b(seq_b),
        .start_row(start_row),
        .start_col(start_col),
        .op_valid(op_valid),
        .op_ready(op_ready),
        .op_code(op_code),
        .op_row(op_row),
        .op_col(op_col),
        .op_last(op_last),
        .busy(busy),
        .done(done),
        .path_len(path_len)
    );

    typedef struct {
        logic [1:0] code;
        int         row;
        int         col;
        bit         last;
    } op_t;

    op_t               expq[$];
    logic [2*N*N-1:0]  m_mat;
    logic [2*N-1:0]    m_sa;
    logic [2*N-1:0]    m_sb;
    int                m_sr;
    int                m_sc;
    int                vectors = 0;
    int                miscompares = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] cellDir(input int r, input int c);
        return m_mat[(r*N+c)*2 +: 2];
    endfunction

    // Reference: follow arrows from the start cell, one op per visited non-STOP cell
    task automatic buildExpected();
        int r, c, pr, pc;
        logic [1:0] d;
        op_t op;
        expq.delete();
        r = m_sr;
        c = m_sc;
        if (cellDir(r, c) == 2'b00) return;
        forever begin
            d = cellDir(r, c);
            if (d == 2'b01) op.code = (m_sa[2*r +: 2] == m_sb[2*c +: 2]) ? 2'b00 : 2'b01;
            else            op.code = d;
            pr = (d == 2'b11) ? r : r - 1;
            pc = (d == 2'b10) ? c : c - 1;
            op.row  = r;
            op.col  = c;
            op.last = (pr < 0) || (pc < 0) || (cellDir(pr, pc) == 2'b00) || (expq.size() + 1 == 2*N-1);
            expq.push_back(op);
            if (op.last) break;
            r = pr;
            c = pc;
        end
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        tb_matrix = m_mat;
        seq_a     = m_sa;
        seq_b     = m_sb;
        start_row = AW'(m_sr);
        start_col = AW'(m_sc);
        start     = 1'b1;
        @(posedge clk);
    endtask

    task automatic randomMatrix();
        for (int i = 0; i < 2*N*N/32; i++) m_mat[32*i +: 32] = $urandom;
        m_sa = {$urandom};
        m_sb = {$urandom};
    endtask

    task automatic diagSetup();
        m_mat = {(N*N){2'b01}};
        for (int i = 0; i < N; i++) begin
            m_sa[2*i +: 2] = 2'(i % 4);
            m_sb[2*i +: 2] = 2'(i % 4);
        end
        m_sr = N-1;
        m_sc = N-1;
    endtask

    // One walk: optional input disturbance during WALK and optional reset abort
    task automatic runWalk(input string name, input int ready_pct, input bit disturb, input int abort_at);
        int  exp_len;
        bit  seen_done;
        bit  stalled;
        op_t held;
        op_t head;
        buildExpected();
        exp_len   = expq.size();
        seen_done = 1'b0;
        stalled   = 1'b0;
        applyStimulus();
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start = disturb;
                if (disturb) begin
                    for (int i = 0; i < 2*N*N/32; i++) tb_matrix[32*i +: 32] = $urandom;
                    seq_a     = {$urandom};
                    seq_b     = {$urandom};
                    start_row = AW'($urandom);
                    start_col = AW'($urandom);
                end
            end
            if (cyc == 4) start = 1'b0;
            if (stalled) begin
                checkOutput({name, "_stall_valid"}, op_valid, 1);
                checkOutput({name, "_stall_code"}, op_code, held.code);
                checkOutput({name, "_stall_row"}, op_row, held.row);
                checkOutput({name, "_stall_col"}, op_col, held.col);
                checkOutput({name, "_stall_last"}, op_last, held.last);
            end
            if (done) begin
                seen_done = 1'b1;
                checkOutput({name, "_done_busy"}, busy, 0);
                checkOutput({name, "_done_valid"}, op_valid, 0);
                checkOutput({name, "_path_len"}, path_len, exp_len);
                checkOutput({name, "_ops_left"}, expq.size(), 0);
                if (ready_pct >= 100)
                    checkOutput({name, "_done_cycle"}, cyc, (exp_len == 0) ? 2 : exp_len + 1);
                break;
            end
            checkOutput({name, "_busy"}, busy, 1);
            if (op_valid) begin
                if (expq.size() == 0) begin
                    checkOutput({name, "_extra_op"}, 1, 0);
                end else begin
                    head = expq[0];
                    checkOutput({name, "_code"}, op_code, head.code);
                    checkOutput({name, "_row"}, op_row, head.row);
                    checkOutput({name, "_col"}, op_col, head.col);
                    checkOutput({name, "_last"}, op_last, head.last);
                end
            end
            if (abort_at == cyc) begin
                rst      = 1'b1;
                op_ready = 1'b1;
                @(negedge clk);
                checkOutput({name, "_rst_valid"}, op_valid, 0);
                checkOutput({name, "_rst_code"}, op_code, 0);
                checkOutput({name, "_rst_row"}, op_row, 0);
                checkOutput({name, "_rst_col"}, op_col, 0);
                checkOutput({name, "_rst_last"}, op_last, 0);
                checkOutput({name, "_rst_busy"}, busy, 0);
                checkOutput({name, "_rst_done"}, done, 0);
                checkOutput({name, "_rst_plen"}, path_len, 0);
                rst = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    checkOutput({name, "_abort_done"}, done, 0);
                    checkOutput({name, "_abort_busy"}, busy, 0);
                end
                return;
            end
            op_ready = ($urandom_range(99) < ready_pct);
            stalled  = op_valid && !op_ready;
            held.code = op_code;
            held.row  = op_row;
            held.col  = op_col;
            held.last = op_last;
            if (op_valid && op_ready && expq.size() != 0) void'(expq.pop_front());
        end
        if (!seen_done) checkOutput({name, "_timeout"}, 0, 1);
        start = 1'b0;
        @(negedge clk);
        checkOutput({name, "_done_pulse"}, done, 0);
        checkOutput({name, "_idle_busy"}, busy, 0);
        checkOutput({name, "_plen_hold"}, path_len, exp_len);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        op_ready  = 1'b1;
        tb_matrix = '0;
        seq_a     = '0;
        seq_b     = '0;
        start_row = '0;
        start_col = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_valid", op_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_plen", path_len, 0);
        rst = 1'b0;

        $display("[TB] all-DIAG walk from (15,15)");
        diagSetup();
        runWalk("diag", 100, 1'b0, 0);

        $display("[TB] STOP at start cell");
        randomMatrix();
        m_sr = 7;
        m_sc = 9;
        m_mat[(m_sr*N+m_sc)*2 +: 2] = 2'b00;
        runWalk("stop", 100, 1'b0, 0);

        $display("[TB] mixed short path");
        randomMatrix();
        m_mat[(3*N+3)*2 +: 2] = 2'b01;
        m_mat[(2*N+2)*2 +: 2] = 2'b10;
        m_mat[(1*N+2)*2 +: 2] = 2'b11;
        m_mat[(1*N+1)*2 +: 2] = 2'b01;
        m_mat[(0*N+0)*2 +: 2] = 2'b00;
        m_sa[2*3 +: 2] = 2'd1;
        m_sb[2*3 +: 2] = 2'd2;
        m_sr = 3;
        m_sc = 3;
        runWalk("mixed", 100, 1'b0, 0);

        $display("[TB] all-DIAG with random backpressure");
        diagSetup();
        runWalk("diag_bp", 50, 1'b0, 0);

        $display("[TB] all-DIAG with start and inputs disturbed during walk");
        diagSetup();
        runWalk("disturb", 100, 1'b1, 0);

        $display("[TB] reset during 5th op, then fresh walk");
        diagSetup();
        runWalk("abort", 100, 1'b0, 5);
        diagSetup();
        runWalk("after_abort", 100, 1'b0, 0);

        $display("[TB] random matrices");
        for (int t = 0; t < 8; t++) begin
            randomMatrix();
            m_sr = $urandom_range(N-1);
            m_sc = $urandom_range(N-1);
            runWalk("rand", $urandom_range(100, 30), 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/traceback_walker.md
Name: traceback_walker

Overview:
Consumes the direction matrix and the max-score cell coordinates produced by the 16x16 alignment scoring array. It walks the path back from that cell and emits one alignment operation per cycle on a valid/ready stream. It is the read side of the traceback matrix, and it sits between the scoring array and the alignment output formatter.

Parameters:
N, 16, matrix dimension (rows index seqA, columns index seqB)
AW, 4, coordinate width, equal to clog2(N)
LW, 6, path-length counter width; must hold 2N-1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a walk; sampled in IDLE only
tb_matrix  in  2*N*N  direction of cell (r,c) at bits [(r*N+c)*2 +: 2]
seq_a  in  2*N  seqA element r at bits [2r +: 2]
seq_b  in  2*N  seqB element c at bits [2c +: 2]
start_row  in  AW  row of the max-score cell
start_col  in  AW  column of the max-score cell
op_valid  out  1  op_* fields are valid
op_ready  in  1  downstream accepts the op
op_code  out  2  00 match, 01 mismatch, 10 gap in B (up), 11 gap in A (left)
op_row  out  AW  row of the emitted cell
op_col  out  AW  column of the emitted cell
op_last  out  1  final op of the path
busy  out  1  walk in progress
done  out  1  one-cycle pulse when the walk ends
path_len  out  LW  ops emitted in the last walk; holds until the next start

Behaviour:
- Direction encoding:
  - 00 STOP: local start, no predecessor.
  - 01 DIAG: predecessor is (r-1, c-1).
  - 10 UP: predecessor is (r-1, c).
  - 11 LEFT: predecessor is (r, c-1).
- Reset: state IDLE; op_valid, op_code, op_row, op_col, op_last, busy, done and path_len all 0. Reset asserted mid-walk aborts the walk at the next edge. No done pulse is produced for an aborted walk.
- States: IDLE, WALK, FIN.
  - IDLE: when start=1, register tb_matrix, seq_a, seq_b, start_row and start_col, clear path_len, and go to WALK. busy=1 from the next cycle.
  - start is ignored in WALK and FIN. Inputs may change freely after capture.
- WALK, with current cell (r,c) read from the captured matrix:
  - If dir(r,c)=STOP: emit nothing and go to FIN. This can only happen on the first cell; a STOP start gives path_len=0.
  - Otherwise present the op with op_valid=1, op_row=r, op_col=c.
  - op_code for DIAG: 00 if seq_a[r]==seq_b[c], else 01. UP gives 10; LEFT gives 11.
- op_last=1 when any of these holds:
  - the predecessor lies outside the matrix (r=0 with DIAG or UP; c=0 with DIAG or LEFT);
  - the predecessor's direction is STOP;
  - path_len+1 = 2N-1 (guard; unreachable with legal data).
- Handshake:
  - An op transfers on a cycle with op_valid & op_ready.
  - While op_valid & !op_ready, every op_* field holds stable.
  - op_valid never drops without a transfer, except on reset.
- On transfer: path_len increments. If op_last, go to FIN with op_valid=0 next cycle. Otherwise (r,c) moves to the predecessor and the next op is valid the following cycle, giving back-to-back ops at 1/cycle with op_ready held high.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE. path_len is valid during and after the done pulse.
- Latency: start sampled at edge N gives the first op_valid at N+1. A path of L ops with op_ready tied high gives done at N+L+1.
- Coordinates never wrap. Out-of-range moves are prevented by the op_last rule.

Test Plan:
- All-DIAG matrix, seq_a = seq_b = 0..3 repeating, start (15,15), op_ready=1 -> 16 ops, cells (15,15) to (0,0), all op_code 00. op_last on (0,0); done on cycle 17 after start; path_len=16.
- Start cell direction STOP -> no op_valid; done pulses on cycle 2 after start; path_len=0.
- Path (3,3) DIAG, (2,2) UP, (1,2) LEFT, (1,1) DIAG, (0,0) STOP, with seq_a[3]=1 and seq_b[3]=2 -> codes 01, 10, 11, then 00 or 01 per sequences. op_last on (1,1); path_len=4.
- Random op_ready at 50% on the all-DIAG case -> op_* stable while stalled, no lost or duplicate ops, same 16-op sequence.
- Assert start during WALK, and change tb_matrix after capture -> walk unaffected; second start ignored.
- Reset asserted on the 5th op of a walk -> next cycle all outputs 0 and state IDLE; no done. A fresh start then completes normally.
